// File: rtl/traffic_ctrl_2way.sv
// ---------------------------------------------------------------------------
// traffic_ctrl_2way
//
// Two-approach intersection controller. Two active-low RGB heads (A and B)
// run through green / yellow / all-red. A latched pedestrian request adds a
// walk phase after B's all-red clearance. All phase lengths are whole ticks
// of a shared free-running divider.
//
// Ports:
//   sys_clk     in   clock
//   sys_rst     in   synchronous reset, active-high
//   ped_req     in   pedestrian button (level or pulse), sampled every cycle
//   night_mode  in   only with TL_NIGHT_FLASH_EN: flashing-yellow night mode
//   led_a[2:0]  out  head A, active-low {yellow,red,green}
//   led_b[2:0]  out  head B, same encoding as led_a
//   walk        out  pedestrian walk lamp, active-high
//   ped_ack     out  one-cycle pulse on the first cycle of the walk phase
//   phase[2:0]  out  current state code (debug)
//
// Build option:
//   TL_NIGHT_FLASH_EN  adds night_mode input and the FLASH state (code 7).
// ---------------------------------------------------------------------------
module traffic_ctrl_2way #(
  parameter int TICK_CYCLES = 24_000_000,
  parameter int T_GREEN_A   = 5,
  parameter int T_GREEN_B   = 5,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 4,
  parameter int TW          = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ped_req,
`ifdef TL_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] led_a,
  output logic [2:0] led_b,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED_A = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    ALLRED_B = 3'd5,
    WALK     = 3'd6,
    FLASH    = 3'd7
  } state_t;

  localparam int DW = $clog2(TICK_CYCLES);

  localparam logic [2:0] LED_GREEN  = 3'b110;
  localparam logic [2:0] LED_RED    = 3'b101;
  localparam logic [2:0] LED_YELLOW = 3'b011;

  logic [DW-1:0] div;
  logic          tick;
  logic [TW-1:0] timer;
  state_t        state;
  state_t        nxt;
  logic          go;
  logic          ped_pending;

  // Phase length in ticks for the state being timed.
  function automatic logic [TW-1:0] dur(input state_t s);
    case (s)
      A_GREEN:  dur = TW'(T_GREEN_A);
      B_GREEN:  dur = TW'(T_GREEN_B);
      A_YELLOW,
      B_YELLOW: dur = TW'(T_YELLOW);
      WALK:     dur = TW'(T_WALK);
      default:  dur = TW'(T_ALLRED);
    endcase
  endfunction

  // Lamp pattern on entry to a state: {led_a, led_b, walk}.
  function automatic logic [6:0] lamps(input state_t s);
    case (s)
      A_GREEN:  lamps = {LED_GREEN,  LED_RED,    1'b0};
      A_YELLOW: lamps = {LED_YELLOW, LED_RED,    1'b0};
      B_GREEN:  lamps = {LED_RED,    LED_GREEN,  1'b0};
      B_YELLOW: lamps = {LED_RED,    LED_YELLOW, 1'b0};
      WALK:     lamps = {LED_RED,    LED_RED,    1'b1};
      FLASH:    lamps = {LED_YELLOW, LED_YELLOW, 1'b0};
      default:  lamps = {LED_RED,    LED_RED,    1'b0};
    endcase
  endfunction

  assign tick  = (div == DW'(TICK_CYCLES - 1));
  assign phase = state;

  // Decide whether the FSM moves on this edge and where to. A phase ends on
  // the tick that completes its last tick period. Night mode, when built in,
  // overrides the normal sequence on any tick.
  always_comb begin
    go  = tick && (timer == dur(state) - TW'(1));
    nxt = state;
    case (state)
      A_GREEN:  nxt = A_YELLOW;
      A_YELLOW: nxt = ALLRED_A;
      ALLRED_A: nxt = B_GREEN;
      B_GREEN:  nxt = B_YELLOW;
      B_YELLOW: nxt = ALLRED_B;
      ALLRED_B: nxt = ped_pending ? WALK : A_GREEN;
      WALK:     nxt = A_GREEN;
      default:  nxt = ALLRED_B;
    endcase
`ifdef TL_NIGHT_FLASH_EN
    if (state == FLASH) begin
      go  = tick && !night_mode;
      nxt = ALLRED_B;
    end else if (tick && night_mode) begin
      go  = 1'b1;
      nxt = FLASH;
    end
`endif
  end

  // Divider, phase timer, request latch and state with registered lamps.
  // The divider only ever restarts on reset, so every phase starts on a
  // tick boundary and lasts exactly its tick count. A request arriving on
  // the edge that enters WALK is absorbed by that walk (clear wins).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div         <= '0;
      timer       <= '0;
      state       <= ALLRED_B;
      led_a       <= LED_RED;
      led_b       <= LED_RED;
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      div     <= tick ? '0 : div + DW'(1);
      ped_ack <= 1'b0;

      if (go) begin
        timer                 <= '0;
        state                 <= nxt;
        {led_a, led_b, walk}  <= lamps(nxt);
        if (nxt == WALK) ped_ack <= 1'b1;
      end else if (tick) begin
        if (state == FLASH) begin
          // Alternate yellow and dark; the timer is not used while flashing.
          led_a <= led_a ^ 3'b100;
          led_b <= led_b ^ 3'b100;
        end else begin
          timer <= timer + TW'(1);
        end
      end

      if (go && nxt == WALK)
        ped_pending <= 1'b0;
      else if (ped_req && state != WALK)
        ped_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// ---------------------------------------------------------------------------
// tb_traffic_ctrl_2way
//
// Directed bench for traffic_ctrl_2way with TICK_CYCLES=4 and default phase
// lengths: reset, free-run timing, pedestrian walk, request absorption,
// mid-run reset and (when TL_NIGHT_FLASH_EN is defined) night flashing.
// ---------------------------------------------------------------------------
module tb_traffic_ctrl_2way;

  logic       sys_clk;
  logic       sys_rst;
  logic       ped_req;
`ifdef TL_NIGHT_FLASH_EN
  logic       night_mode;
`endif
  logic [2:0] led_a;
  logic [2:0] led_b;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_ctrl_2way #(
    .TICK_CYCLES(4),
    .T_GREEN_A  (5),
    .T_GREEN_B  (5),
    .T_YELLOW   (2),
    .T_ALLRED   (1),
    .T_WALK     (4),
    .TW         (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .ped_req   (ped_req),
`ifdef TL_NIGHT_FLASH_EN
    .night_mode(night_mode),
`endif
    .led_a     (led_a),
    .led_b     (led_b),
    .walk      (walk),
    .ped_ack   (ped_ack),
    .phase     (phase)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Expected lamps per state code: {led_a, led_b, walk}.
  function automatic logic [6:0] expLamps(input int code);
    case (code)
      0:       expLamps = {3'b110, 3'b101, 1'b0};
      1:       expLamps = {3'b011, 3'b101, 1'b0};
      3:       expLamps = {3'b101, 3'b110, 1'b0};
      4:       expLamps = {3'b101, 3'b011, 1'b0};
      6:       expLamps = {3'b101, 3'b101, 1'b1};
      default: expLamps = {3'b101, 3'b101, 1'b0};
    endcase
  endfunction

  task automatic applyStimulus(input logic rst, input logic req);
    sys_rst = rst;
    ped_req = req;
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] ea,
                             input logic [2:0] eb, input logic ew,
                             input logic eack, input logic [2:0] ephase);
    n_checks++;
    assert (led_a === ea) else begin
      n_fail++;
      $error("[TB] FAIL %s led_a: observed %b expected %b", tag, led_a, ea);
    end
    n_checks++;
    assert (led_b === eb) else begin
      n_fail++;
      $error("[TB] FAIL %s led_b: observed %b expected %b", tag, led_b, eb);
    end
    n_checks++;
    assert (walk === ew) else begin
      n_fail++;
      $error("[TB] FAIL %s walk: observed %b expected %b", tag, walk, ew);
    end
    n_checks++;
    assert (ped_ack === eack) else begin
      n_fail++;
      $error("[TB] FAIL %s ped_ack: observed %b expected %b", tag, ped_ack, eack);
    end
    n_checks++;
    assert (phase === ephase) else begin
      n_fail++;
      $error("[TB] FAIL %s phase: observed %0d expected %0d", tag, phase, ephase);
    end
  endtask

  // Expect state 'code' for n consecutive cycles starting now (the sample
  // just after entry), then advance onto the edge that should leave it.
  task automatic holdPhase(input int code, input int n, input bit entry);
    logic [6:0] e;
    e = expLamps(code);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("ph%0d_c%0d", code, i), e[6:4], e[3:1], e[0],
                  (code == 6 && entry && i == 0), 3'(code));
      n_checks++;
      assert (!(led_a !== 3'b101 && led_b !== 3'b101)) else begin
        n_fail++;
        $error("[TB] FAIL safety: observed a=%b b=%b expected at least one 101",
               led_a, led_b);
      end
      stepCycle();
    end
  endtask

  task automatic fullRoundNoWalk();
    holdPhase(0, 20, 1);
    holdPhase(1, 8, 1);
    holdPhase(2, 4, 1);
    holdPhase(3, 20, 1);
    holdPhase(4, 8, 1);
    holdPhase(5, 4, 1);
  endtask

  initial begin
`ifdef TL_NIGHT_FLASH_EN
    night_mode = 1'b0;
`endif
    // Reset held for three edges.
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset", 3'b101, 3'b101, 1'b0, 1'b0, 3'd5);

    // Release: ALLRED_B for one tick (4 cycles), then A_GREEN.
    applyStimulus(1'b0, 1'b0);
    holdPhase(5, 4, 0);

    // Free run: 20/8/4/20/8/4, twice, no walk.
    fullRoundNoWalk();
    fullRoundNoWalk();

    // One-cycle request mid A_GREEN gives a 16-cycle walk after ALLRED_B.
    holdPhase(0, 5, 1);
    applyStimulus(1'b0, 1'b1);
    holdPhase(0, 1, 0);
    applyStimulus(1'b0, 1'b0);
    holdPhase(0, 14, 0);
    holdPhase(1, 8, 1);
    holdPhase(2, 4, 1);
    holdPhase(3, 20, 1);
    holdPhase(4, 8, 1);
    holdPhase(5, 4, 1);
    holdPhase(6, 16, 1);

    // Request again, then pulse on the exact ALLRED_B->WALK edge and during
    // WALK: one walk only, next ALLRED_B goes straight to A_GREEN.
    holdPhase(0, 3, 1);
    applyStimulus(1'b0, 1'b1);
    holdPhase(0, 1, 0);
    applyStimulus(1'b0, 1'b0);
    holdPhase(0, 16, 0);
    holdPhase(1, 8, 1);
    holdPhase(2, 4, 1);
    holdPhase(3, 20, 1);
    holdPhase(4, 8, 1);
    holdPhase(5, 3, 1);
    applyStimulus(1'b0, 1'b1);
    holdPhase(5, 1, 0);
    applyStimulus(1'b0, 1'b0);
    holdPhase(6, 2, 1);
    applyStimulus(1'b0, 1'b1);
    holdPhase(6, 1, 0);
    applyStimulus(1'b0, 1'b0);
    holdPhase(6, 13, 0);
    fullRoundNoWalk();
    holdPhase(0, 4, 1);

    // Reset for one cycle mid B_GREEN.
    holdPhase(0, 16, 0);
    holdPhase(1, 8, 1);
    holdPhase(2, 4, 1);
    holdPhase(3, 6, 1);
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("midrst", 3'b101, 3'b101, 1'b0, 1'b0, 3'd5);
    holdPhase(5, 4, 0);
    holdPhase(0, 20, 1);
    holdPhase(1, 4, 1);

`ifdef TL_NIGHT_FLASH_EN
    // Night mode raised mid B_GREEN: FLASH at the next tick, 011/111 every
    // 4 cycles, then ALLRED_B at the first tick after night_mode drops.
    holdPhase(1, 4, 0);
    holdPhase(2, 4, 1);
    holdPhase(3, 6, 1);
    night_mode = 1'b1;
    holdPhase(3, 2, 0);
    for (int k = 0; k < 12; k++) begin
      if ((k / 4) % 2 == 0)
        checkOutput($sformatf("flash_c%0d", k), 3'b011, 3'b011, 1'b0, 1'b0, 3'd7);
      else
        checkOutput($sformatf("flash_c%0d", k), 3'b111, 3'b111, 1'b0, 1'b0, 3'd7);
      if (k == 8) night_mode = 1'b0;
      stepCycle();
    end
    holdPhase(5, 4, 1);
    holdPhase(0, 4, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
